// File: rtl/led_fade.sv
// Four-channel LED fader. Each channel's brightness ramps one step at a time
// toward its target, and a free-running PWM compare drives the LED pin.
module led_fade #(
  parameter int          PWM_BITS    = 8,
  parameter logic [31:0] STEP_CYCLES = 32'd1000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [3:0]          led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [3:0]          led_out,
  output logic [3:0]          fade_busy
);

  localparam logic [PWM_BITS-1:0] MAXL = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RISE,
    ST_HOLD,
    ST_FALL
  } state_e;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]         step_cnt_q, step_cnt_d;
  logic                step_tick;
  logic [PWM_BITS-1:0] tgt [4];
  logic [PWM_BITS-1:0] lvl_q [4];
  logic [PWM_BITS-1:0] lvl_d [4];
  state_e              state_q [4];
  state_e              state_d [4];
  logic [3:0]          led_out_q, led_out_d;

  always_comb begin
    step_tick  = (step_cnt_q == STEP_CYCLES - 32'd1);
    pwm_cnt_d  = pwm_cnt_q + ONE;
    step_cnt_d = step_tick ? 32'd0 : step_cnt_q + 32'd1;
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    led_out_d = '0;
    for (int i = 0; i < 4; i++) begin
      tgt[i]     = led_in[i] ? brightness : '0;
      lvl_d[i]   = lvl_q[i];
      state_d[i] = ST_OFF;

      // lvl moves by one toward tgt, so it can never step past it.
      if (step_tick) begin
        if (lvl_q[i] < tgt[i])      lvl_d[i] = lvl_q[i] + ONE;
        else if (lvl_q[i] > tgt[i]) lvl_d[i] = lvl_q[i] - ONE;
      end

      if (lvl_q[i] < tgt[i])       state_d[i] = ST_RISE;
      else if (lvl_q[i] > tgt[i])  state_d[i] = ST_FALL;
      else if (lvl_q[i] != '0)     state_d[i] = ST_HOLD;

      led_out_d[i] = (lvl_q[i] == MAXL) || (pwm_cnt_q < lvl_q[i]);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order. The level array is small
  // and is reset explicitly, since a mid-fade reset must clear it at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      led_out_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        lvl_q[i]   <= '0;
        state_q[i] <= ST_OFF;
      end
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_out_q  <= led_out_d;
      for (int i = 0; i < 4; i++) begin
        lvl_q[i]   <= lvl_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    fade_busy = '0;
    for (int i = 0; i < 4; i++) begin
      fade_busy[i] = (state_q[i] == ST_RISE) || (state_q[i] == ST_FALL);
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade: directed fade scenarios plus random segments, checked
// against a cycle-count model built from the fade and PWM rules.
module tb_led_fade;

  localparam int PW     = 4;
  localparam int SC     = 4;
  localparam int MAXL   = (1 << PW) - 1;
  localparam int PERIOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    led_in = '0;
  logic [PW-1:0] bri = '0;
  logic [3:0]    led_out;
  logic [3:0]    busy;

  int n_checks = 0;
  int n_errors = 0;

  // model state: cycles since reset release and the level of each channel
  int         n;
  int         lvl [4];
  logic [3:0] exp_led;
  logic [3:0] exp_busy;

  always #10 clk = ~clk;

  led_fade #(
    .PWM_BITS   (PW),
    .STEP_CYCLES(32'(SC))
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .led_in    (led_in),
    .brightness(bri),
    .led_out   (led_out),
    .fade_busy (busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int tgt(input int i);
    return led_in[i] ? int'(bri) : 0;
  endfunction

  function automatic void model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) lvl[i] = 0;
  endfunction

  // Called at a falling edge with the inputs for the coming rising edge already
  // applied; predicts the outputs that edge produces and checks them.
  task automatic cycle();
    for (int i = 0; i < 4; i++) begin
      int t;
      t = tgt(i);
      exp_led[i]  = (lvl[i] == MAXL) || ((n % PERIOD) < lvl[i]);
      exp_busy[i] = (lvl[i] != t);
      if ((n % SC) == SC - 1) begin
        if (lvl[i] < t)      lvl[i] = lvl[i] + 1;
        else if (lvl[i] > t) lvl[i] = lvl[i] - 1;
      end
    end
    n++;
    @(negedge clk);
    check("led_out", 8'(led_out), 8'(exp_led));
    check("fade_busy", 8'(busy), 8'(exp_busy));
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) cycle();
  endtask

  initial begin
    int cnt_dut;
    int cnt_mdl;
    int guard;

    // 1: outputs stay low throughout reset even with every channel requested
    led_in = 4'hF;
    bri    = 4'd15;
    repeat (5) begin
      @(negedge clk);
      check("rst_led", 8'(led_out), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
    end
    rst_n = 1'b1;
    model_reset();

    // 2: fade-in on channel 0, then a full PWM period of constant-on
    led_in = 4'b0001;
    bri    = 4'd15;
    run(70);
    for (int k = 0; k < PERIOD; k++) begin
      cycle();
      check("full_on", 8'(led_out), 8'h01);
    end

    // 3: channel 1 at level 4 is high 4 of every 16 clocks
    led_in = 4'b0010;
    bri    = 4'd4;
    run(100);
    cnt_dut = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cycle();
      cnt_dut += int'(led_out[1]);
    end
    check("duty_ch1", 8'(cnt_dut), 8'd4);

    // 4: reverse channel 2 mid-ramp at level 6
    led_in = 4'b0100;
    bri    = 4'd15;
    guard  = 0;
    while (lvl[2] != 6 && guard < 200) begin
      cycle();
      guard++;
    end
    check("reach_lvl6", 8'(guard < 200), 8'd1);
    led_in = 4'b0000;
    run(40);
    check("rev_busy", 8'(busy), 8'h0);
    check("rev_led", 8'(led_out), 8'h0);

    // 5: channel 3 held at 15, ceiling lowered to 8
    led_in = 4'b1000;
    bri    = 4'd15;
    run(70);
    bri     = 4'd8;
    cnt_dut = 0;
    cnt_mdl = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      cnt_dut += int'(busy[3]);
      cnt_mdl += int'(exp_busy[3]);
    end
    check("desc_len", 8'(cnt_dut), 8'(cnt_mdl));
    check("desc_done", 8'(busy), 8'h0);

    // 6: asynchronous reset while channel 0 sits at level 9
    led_in = 4'b0001;
    bri    = 4'd15;
    guard  = 0;
    while (lvl[0] != 9 && guard < 200) begin
      cycle();
      guard++;
    end
    check("reach_lvl9", 8'(guard < 200), 8'd1);
    #4 rst_n = 1'b0;
    #1;
    check("async_led", 8'(led_out), 8'h0);
    check("async_busy", 8'(busy), 8'h0);
    @(negedge clk);
    check("async_hold", 8'(led_out | busy), 8'h0);
    rst_n = 1'b1;
    model_reset();
    run(80);

    // zero ceiling: everything fades out whatever led_in says
    led_in = 4'hF;
    bri    = 4'd0;
    run(70);
    check("zero_bri", 8'(led_out | busy), 8'h0);

    // random segments of held inputs
    for (int s = 0; s < 30; s++) begin
      led_in = 4'($urandom);
      bri    = PW'($urandom_range(0, MAXL));
      run(int'($urandom_range(3, 90)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
